// File: rtl/button_inc_pulser.sv
// Push-button conditioner: 2-flop synchroniser, debounce FSM and one-cycle inc strobe per press.
// Define AUTO_REPEAT_EN to add hold-to-repeat strobes while the button stays pressed.
module button_inc_pulser #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 26,
  parameter int unsigned REPEAT_DELAY    = 50000000,
  parameter int unsigned REPEAT_PERIOD   = 10000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic inc,
  output logic held
);

  localparam int unsigned CNT_MAX_A = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int unsigned CNT_MAX   = (CNT_MAX_A > REPEAT_PERIOD) ? CNT_MAX_A : REPEAT_PERIOD;
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Reject configurations whose counts do not fit the counters or break the FSM.
  if (DEBOUNCE_CYCLES < 2 || REPEAT_PERIOD < 2 || REPEAT_DELAY < 1 ||
      (64'(CNT_MAX - 1) >> CNT_W) != 64'd0) begin : g_bad_cfg
    $error("button_inc_pulser: invalid parameter set");
  end

  typedef enum logic [1:0] {
    IDLE,
    DB_PRESS,
    PRESSED,
    DB_RELEASE
  } state_e;

  state_e           state_q;
  logic             sync1_q;
  logic             btn_s_q;
  logic [CNT_W-1:0] cnt_q;
  logic             inc_q;
  logic             held_q;

`ifdef AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);
  logic [CNT_W-1:0] rcnt_q;
  logic             rep_first_q;  // next repeat uses the initial delay, not the period
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q     <= 1'b0;
      btn_s_q     <= 1'b0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      inc_q       <= 1'b0;
      held_q      <= 1'b0;
`ifdef AUTO_REPEAT_EN
      rcnt_q      <= '0;
      rep_first_q <= 1'b1;
`endif
    end else begin
      sync1_q <= btn_in;
      btn_s_q <= sync1_q;
      // NOTE: non-blocking defaults first; a later assignment in the case below wins on the same edge.
      inc_q   <= 1'b0;
`ifdef AUTO_REPEAT_EN
      rcnt_q      <= '0;
      rep_first_q <= 1'b1;
`endif
      unique case (state_q)
        IDLE: begin
          if (btn_s_q) begin
            state_q <= DB_PRESS;
            cnt_q   <= '0;
          end
        end
        DB_PRESS: begin
          if (!btn_s_q) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == DB_LAST) begin
            state_q <= PRESSED;
            cnt_q   <= '0;
            inc_q   <= 1'b1;
            held_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        PRESSED: begin
          if (!btn_s_q) begin
            state_q <= DB_RELEASE;
            cnt_q   <= '0;
          end else begin
`ifdef AUTO_REPEAT_EN
            if (rcnt_q == (rep_first_q ? RD_LAST : RP_LAST)) begin
              inc_q       <= 1'b1;
              rep_first_q <= 1'b0;
            end else begin
              rcnt_q      <= rcnt_q + 1'b1;
              rep_first_q <= rep_first_q;
            end
`endif
          end
        end
        DB_RELEASE: begin
          if (btn_s_q) begin
            state_q <= PRESSED;
            cnt_q   <= '0;
          end else if (cnt_q == DB_LAST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            held_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          held_q  <= 1'b0;
        end
      endcase
    end
  end

  assign inc  = inc_q;
  assign held = held_q;

endmodule

// File: tb/tb_button_inc_pulser.sv
// Self-checking bench for button_inc_pulser: directed scenarios plus random bursts against a run-length model.
module tb_button_inc_pulser;

  localparam int D  = 4;
  localparam int RD = 8;
  localparam int RP = 3;

  logic clk = 1'b0;
  logic reset;
  logic btn_in;
  logic inc;
  logic held;

  int n_checks = 0;
  int n_err    = 0;
  int edge_no  = 0;
  int inc_total = 0;
  int first_inc_edge;
  int held_fall_edge;
  int mark_edge;
  int mark_incs;
  logic prev_held;

  // Reference model: btn_s is the raw sample two edges back; held flips once a run
  // of the opposite level lasts D+1 FSM edges.
  bit [1:0] hist;
  bit       last_seen;
  bit       m_held;
  bit       m_inc;
  bit       m_first;
  int       ones;
  int       zeros;
  int       age;

  button_inc_pulser #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (8),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .btn_in(btn_in),
    .inc   (inc),
    .held  (held)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s at edge %0d: observed=%0d expected=%0d", tag, edge_no, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist      = '0;
    last_seen = 1'b0;
    m_held    = 1'b0;
    m_inc     = 1'b0;
    m_first   = 1'b1;
    ones      = 0;
    zeros     = 0;
    age       = 0;
    prev_held = 1'b0;
  endtask

  task automatic model_edge(input bit x);
    bit seen;
`ifdef AUTO_REPEAT_EN
    bit was_pressed;
    was_pressed = m_held && last_seen;
`endif
    seen  = hist[1];
    hist  = {hist[0], x};
    m_inc = 1'b0;
    if (seen) begin ones++; zeros = 0; end
    else begin zeros++; ones = 0; end
    if (!m_held && ones == D + 1) begin
      m_held  = 1'b1;
      m_inc   = 1'b1;
      age     = 0;
      m_first = 1'b1;
    end else if (m_held && zeros == D + 1) begin
      m_held = 1'b0;
    end
`ifdef AUTO_REPEAT_EN
    else if (m_held && seen) begin
      if (!was_pressed) begin
        age     = 0;
        m_first = 1'b1;
      end else begin
        age++;
        if (age == (m_first ? RD : RP)) begin
          m_inc   = 1'b1;
          age     = 0;
          m_first = 1'b0;
        end
      end
    end
`endif
    last_seen = seen;
  endtask

  task automatic step(input logic b);
    btn_in = b;
    @(posedge clk);
    edge_no++;
    model_edge(b);
    #1;
    if (inc === 1'b1) begin
      inc_total++;
      if (first_inc_edge < 0) first_inc_edge = edge_no;
    end
    if (prev_held === 1'b1 && held === 1'b0) held_fall_edge = edge_no;
    prev_held = held;
    check("inc", inc, m_inc);
    check("held", held, m_held);
  endtask

  task automatic mark();
    mark_edge      = edge_no + 1;
    mark_incs      = inc_total;
    first_inc_edge = -1;
    held_fall_edge = -1;
  endtask

  task automatic pulse_reset(input int cycles);
    reset = 1'b1;
    model_reset();
    #1;
    check("rst_abort_inc", inc, 0);
    check("rst_abort_held", held, 0);
    repeat (cycles) begin
      @(posedge clk);
      #1;
      check("rst_inc", inc, 0);
      check("rst_held", held, 0);
    end
    reset = 1'b0;
  endtask

  initial begin
    reset  = 1'b1;
    btn_in = 1'b1;
    model_reset();
    mark();
    #1;
    // Reset held with the button down: outputs stay low.
    repeat (10) begin
      @(posedge clk);
      #1;
      check("rst_hold_inc", inc, 0);
      check("rst_hold_held", held, 0);
    end
    reset = 1'b0;

    // Button already down at reset release: full debounce, then a single press.
    mark();
    repeat (20) step(1'b1);
    check("press_edge", first_inc_edge - mark_edge, D + 2);
`ifndef AUTO_REPEAT_EN
    check("press_count", inc_total - mark_incs, 1);
`endif
    mark();
    repeat (10) step(1'b0);
    check("release_edge", held_fall_edge - mark_edge, D + 2);

    // Glitch 1,1,0 rejected; steady high afterwards is accepted once.
    mark();
    step(1'b1); step(1'b1); step(1'b0);
    check("glitch_no_inc", inc_total - mark_incs, 0);
    mark();
    repeat (12) step(1'b1);
    check("glitch_press_edge", first_inc_edge - mark_edge, D + 2);
    check("glitch_press_count", inc_total - mark_incs, 1);
    repeat (10) step(1'b0);

    // Release bounce while pressed: held stays, no new strobe.
    repeat (8) step(1'b1);
    mark();
    step(1'b0); step(1'b0);
    repeat (8) step(1'b1);
    check("bounce_no_inc", inc_total - mark_incs, 0);
    check("bounce_held", held, 1);
    repeat (10) step(1'b0);

    // Reset during debounce with the button kept high.
    repeat (3) step(1'b1);
    pulse_reset(2);
    mark();
    repeat (10) step(1'b1);
    check("post_rst_press_edge", first_inc_edge - mark_edge, D + 2);
    repeat (10) step(1'b0);

    // Long hold: one strobe, or delay/period repeats when enabled.
    mark();
    repeat (25) step(1'b1);
    check("hold_first_edge", first_inc_edge - mark_edge, D + 2);
`ifdef AUTO_REPEAT_EN
    check("hold_count", inc_total - mark_incs, 5);
`else
    check("hold_count", inc_total - mark_incs, 1);
`endif
    repeat (10) step(1'b0);

    // Random bursts with occasional asynchronous resets.
    for (int i = 0; i < 80; i++) begin
      bit lvl;
      int len;
      if ($urandom_range(0, 19) == 0) pulse_reset(int'($urandom_range(1, 3)));
      lvl = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 9) == 0) ? 30 : int'($urandom_range(1, 8));
      repeat (len) step(lvl);
    end
    repeat (10) step(1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
